alu_operand_loader: RTL



---
 rtl/alu_operand_loader.sv | 84 ++++++++
 1 files changed

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: captures A, B and opcode in turn from one switch bus on debounced load presses.
module alu_operand_loader #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn_load,
    input  logic       btn_clear,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [2:0] opcode,
    output logic       valid,
    output logic [1:0] state
);
    localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    typedef enum logic [1:0] {S_A, S_B, S_OP, S_DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic [2:0] op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic s1_q, s2_q, deb_q, deb_d, deb_dly_q, clr1_q, clr2_q, load_evt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            clr1_q    <= 1'b0;
            clr2_q    <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
        end else begin
            s1_q      <= btn_load;
            s2_q      <= s1_q;
            clr1_q    <= btn_clear;
            clr2_q    <= clr1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
        end
    end
    // A level change is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1))
                deb_d = s2_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end
    assign load_evt = deb_q & ~deb_dly_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (clr2_q) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else if (load_evt) begin
            state_d = state_q == S_DONE ? S_B : state_t'(state_q + 2'd1);
            a_d     = (state_q == S_A || state_q == S_DONE) ? sw : a_q;
            b_d     = state_q == S_B ? sw : b_q;
            op_d    = state_q == S_OP ? sw[2:0] : op_q;
        end
    end
    assign A      = a_q;
    assign B      = b_q;
    assign opcode = op_q;
    assign valid  = state_q == S_DONE;
    assign state  = state_q;
endmodule
